// File: rtl/life_map_display.sv
//------------------------------------------------------------------------------
// Module      : life_map_display
// Description : Double-buffered Game-of-Life cell map with bus access, a
//               page-clear engine and a registered pixel colour output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module life_map_display #(
    parameter int          CELLS_X    = 64,
    parameter int          CELLS_Y    = 48,
    parameter int          CELL_SIZE  = 10,
    parameter int          ADDR_W     = 7,
    parameter logic [7:0]  COLOR_LIVE = 8'b000_000_00,
    parameter logic [7:0]  COLOR_DEAD = 8'b111_111_11,
    parameter logic [7:0]  COLOR_GRID = 8'b110_110_10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              block_write,
    input  logic [ADDR_W-1:0] block_address,
    input  logic [31:0]       block_data_in,
    output logic [31:0]       block_data_out,
    input  logic [9:0]        x_position,
    input  logic [8:0]        y_position,
    input  logic              inside_video,
    input  logic              frame_start,
    output logic [7:0]        color,
    output logic              busy
);

    localparam int                c_words         = CELLS_Y * CELLS_X / 32;
    localparam int                c_words_per_row = CELLS_X / 32;
    localparam logic [ADDR_W-1:0] c_ctrl_addr     = '1;
    localparam logic [ADDR_W-1:0] c_words_a       = ADDR_W'(c_words);
    localparam logic [ADDR_W-1:0] c_last_word     = ADDR_W'(c_words - 1);
    localparam logic [ADDR_W-1:0] c_row_words     = ADDR_W'(c_words_per_row);
    localparam logic [9:0]        c_cell_size_x   = 10'(CELL_SIZE);
    localparam logic [8:0]        c_cell_size_y   = 9'(CELL_SIZE);
    localparam logic [9:0]        c_cells_x       = 10'(CELLS_X);
    localparam logic [8:0]        c_cells_y       = 9'(CELLS_Y);

    // Clear engine states
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_clear = 1'b1;

    // Two pages of cell bits; page index is the outer dimension
    logic [31:0]       r_mem [0:1][0:c_words-1];

    logic              r_display_page;
    logic              r_swap_pending;
    logic              r_grid_enable;
    logic              r_busy;
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clear_count;
    logic [7:0]        r_color;

    logic              w_edit_page;
    logic              w_ctrl_wr;
    logic              w_data_hit;
    logic              w_data_wr;
    logic              w_swap_now;
    logic [9:0]        w_cell_x;
    logic [8:0]        w_cell_y;
    logic              w_in_map;
    logic              w_on_grid;
    logic [ADDR_W-1:0] w_pix_addr;
    logic [31:0]       w_pix_word;
    logic              w_pix_live;

    assign w_edit_page = ~r_display_page;
    assign w_ctrl_wr   = block_write && (block_address == c_ctrl_addr);
    assign w_data_hit  = (block_address < c_words_a);
    assign w_data_wr   = block_write && w_data_hit && !r_busy;
    assign w_swap_now  = frame_start && r_swap_pending && !r_busy;

    // Pixel-to-cell mapping; the word address is forced to 0 off-map so the
    // page lookup never leaves the array
    assign w_cell_x   = x_position / c_cell_size_x;
    assign w_cell_y   = y_position / c_cell_size_y;
    assign w_in_map   = inside_video && (w_cell_x < c_cells_x) && (w_cell_y < c_cells_y);
    assign w_on_grid  = ((x_position % c_cell_size_x) == 10'd0) ||
                        ((y_position % c_cell_size_y) == 9'd0);
    assign w_pix_addr = w_in_map ? (ADDR_W'(w_cell_y) * c_row_words + ADDR_W'(w_cell_x >> 5))
                                 : '0;
    assign w_pix_word = r_mem[r_display_page][w_pix_addr];
    assign w_pix_live = w_pix_word[w_cell_x[4:0]];

    assign busy  = r_busy;
    assign color = r_color;

    // Bus read mux: control register, edit-page word, or zero for unused space
    always_comb begin
        block_data_out = '0;
        if (block_address == c_ctrl_addr) begin
            block_data_out = {28'b0, r_grid_enable, r_busy, r_swap_pending, r_display_page};
        end else if (w_data_hit) begin
            block_data_out = r_mem[w_edit_page][block_address];
        end
    end

    // Page memory writes; never reset, and a reset edge suppresses any write
    // so an aborted clear leaves the remaining words intact
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (r_busy) begin
                r_mem[w_edit_page][r_clear_count] <= '0;
            end else if (w_data_wr) begin
                r_mem[w_edit_page][block_address] <= block_data_in;
            end
        end
    end

    // Control state: clear engine, page swap and grid enable
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= c_st_idle;
            r_busy         <= 1'b0;
            r_clear_count  <= '0;
            r_display_page <= 1'b0;
            r_swap_pending <= 1'b0;
            r_grid_enable  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_ctrl_wr && block_data_in[1]) begin
                        r_state       <= c_st_clear;
                        r_busy        <= 1'b1;
                        r_clear_count <= '0;
                    end
                end
                c_st_clear: begin
                    if (r_clear_count == c_last_word) begin
                        r_state       <= c_st_idle;
                        r_busy        <= 1'b0;
                        r_clear_count <= '0;
                    end else begin
                        r_clear_count <= r_clear_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase

            // A pending swap is consumed at frame start; a fresh request in
            // the same cycle re-arms it
            if (w_swap_now) begin
                r_display_page <= ~r_display_page;
                r_swap_pending <= 1'b0;
            end
            if (w_ctrl_wr && block_data_in[0]) begin
                r_swap_pending <= 1'b1;
            end
            if (w_ctrl_wr) begin
                r_grid_enable <= block_data_in[2];
            end
        end
    end

    // Registered pixel colour with blanking, grid, live and dead priority
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_color <= 8'h00;
        end else if (!w_in_map) begin
            r_color <= 8'h00;
        end else if (r_grid_enable && w_on_grid) begin
            r_color <= COLOR_GRID;
        end else if (w_pix_live) begin
            r_color <= COLOR_LIVE;
        end else begin
            r_color <= COLOR_DEAD;
        end
    end

endmodule

`default_nettype wire
